// File: rtl/finish_monitor_pkg.sv
// Shared types and constants for the end-of-program monitor.
package finish_monitor_pkg;

  localparam int DEF_XLEN = 32;
  localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_1000;
  localparam logic [63:0] TIMEOUT_EXIT_CODE = '1;

  typedef enum logic {
    RUN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_TOHOST,
    CAUSE_LOOP,
    CAUSE_TIMEOUT
  } cause_t;

endpackage

// File: rtl/finish_monitor_if.sv
// Core snoop bundle: retire strobe, PC and data-memory write port.
interface finish_monitor_if #(
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic [XLEN-1:0] pc;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;

  modport master (
    output instr_valid, pc,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input instr_valid, pc,
    input mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/finish_monitor_sat_counter.sv
// Saturating up-counter with sync active-low clear and load.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (!clr)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/finish_monitor.sv
// Decides when a program has ended: tohost write,
// self-loop or timeout; latches cause, code and stats.
module finish_monitor
  import finish_monitor_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter logic [XLEN-1:0] TOHOST_ADDR =
    XLEN'(DEF_TOHOST_ADDR),
  parameter int LOOP_THRESH = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic            clock,
  input  logic            rst,
  finish_monitor_if.slave snoop,
  output logic            finish_flag,
  output logic            pass,
  output logic [1:0]      cause,
  output logic [XLEN-2:0] exit_code,
  output logic [31:0]     cycle_count,
  output logic [31:0]     instr_count
);

  localparam int LW = $clog2(LOOP_THRESH + 1);

  state_t state_q;
  state_t state_d;
  logic   run;

  logic [XLEN-1:0] last_pc;
  logic [LW-1:0]   loop_cnt;
  logic            pc_match;

  logic tohost_hit;
  logic loop_hit;
  logic timeout_hit;

  logic            fire;
  cause_t          cause_d;
  logic [XLEN-2:0] code_d;
  logic            pass_d;

  assign run      = (state_q == RUN);
  assign pc_match = (snoop.pc == last_pc);

  assign tohost_hit = snoop.mem_we &&
    (snoop.mem_addr == TOHOST_ADDR) &&
    snoop.mem_wdata[0];

  // An empty loop counter increments to 1, so a
  // first retirement at the reset PC still counts as 1.
  assign loop_hit = snoop.instr_valid && pc_match &&
    (loop_cnt == LW'(LOOP_THRESH - 1));

  assign timeout_hit =
    (cycle_count == 32'(TIMEOUT_CYCLES - 1));

  sat_counter #(.W(32)) u_cycle (
    .clock    (clock),
    .clr      (rst),
    .en       (run),
    .load     (1'b0),
    .load_val ('0),
    .count    (cycle_count)
  );

  sat_counter #(.W(32)) u_instr (
    .clock    (clock),
    .clr      (rst),
    .en       (run && snoop.instr_valid),
    .load     (1'b0),
    .load_val ('0),
    .count    (instr_count)
  );

  sat_counter #(.W(LW)) u_loop (
    .clock    (clock),
    .clr      (rst),
    .en       (run && snoop.instr_valid && pc_match),
    .load     (run && snoop.instr_valid && !pc_match),
    .load_val (LW'(1)),
    .count    (loop_cnt)
  );

  always_ff @(posedge clock) begin
    if (!rst)
      last_pc <= '0;
    else if (run && snoop.instr_valid && !pc_match)
      last_pc <= snoop.pc;
  end

  always_ff @(posedge clock) begin
    if (!rst)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    cause_d = CAUSE_NONE;
    code_d  = '0;
    pass_d  = 1'b0;
    if (run) begin
      priority case (1'b1)
        tohost_hit: begin
          fire    = 1'b1;
          cause_d = CAUSE_TOHOST;
          code_d  = snoop.mem_wdata[XLEN-1:1];
          pass_d  = (snoop.mem_wdata[XLEN-1:1] == '0);
        end
        loop_hit: begin
          fire    = 1'b1;
          cause_d = CAUSE_LOOP;
          pass_d  = 1'b1;
        end
        timeout_hit: begin
          fire    = 1'b1;
          cause_d = CAUSE_TIMEOUT;
          code_d  = TIMEOUT_EXIT_CODE[XLEN-2:0];
        end
        default: ;
      endcase
      if (fire)
        state_d = DONE;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      finish_flag <= 1'b0;
      pass        <= 1'b0;
      cause       <= CAUSE_NONE;
      exit_code   <= '0;
    end else if (fire) begin
      finish_flag <= 1'b1;
      pass        <= pass_d;
      cause       <= cause_d;
      exit_code   <= code_d;
    end
  end

endmodule

// File: tb/tb_finish_monitor.sv
// Directed bench for finish_monitor: tohost, loop,
// timeout, priority, freeze and reset behaviour.
module tb_finish_monitor;

  logic        clock = 1'b0;
  logic        rst;
  logic        finish_flag;
  logic        pass;
  logic [1:0]  cause;
  logic [30:0] exit_code;
  logic [31:0] cycle_count;
  logic [31:0] instr_count;

  int total = 0;
  int bad   = 0;

  finish_monitor_if #(.XLEN(32)) bus ();

  finish_monitor #(
    .XLEN           (32),
    .TOHOST_ADDR    (32'h0000_1000),
    .LOOP_THRESH    (8),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .snoop       (bus.slave),
    .finish_flag (finish_flag),
    .pass        (pass),
    .cause       (cause),
    .exit_code   (exit_code),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.instr_valid = 1'b0;
    bus.pc          = '0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) step();
    rst = 1'b1;
  endtask

  task automatic retire(input logic [31:0] a);
    bus.instr_valid = 1'b1;
    bus.pc          = a;
    step();
    bus.instr_valid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    bus.mem_we    = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    step();
    bus.mem_we    = 1'b0;
  endtask

  task automatic chk_all(
    input string       tag,
    input logic        f,
    input logic        p,
    input logic [1:0]  c,
    input logic [30:0] e
  );
    check({tag, ".flag"}, 64'(finish_flag), 64'(f));
    check({tag, ".pass"}, 64'(pass), 64'(p));
    check({tag, ".cause"}, 64'(cause), 64'(c));
    check({tag, ".code"}, 64'(exit_code), 64'(e));
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #1;

    do_reset(3);
    chk_all("rst", 0, 0, 0, 0);
    check("rst.cyc", 64'(cycle_count), 0);
    check("rst.ins", 64'(instr_count), 0);

    for (int i = 0; i < 5; i++)
      retire(32'(i * 4));
    wr(32'h1000, 32'h2A);
    check("ign.flag", 64'(finish_flag), 0);
    wr(32'h1000, 32'h1);
    chk_all("th", 1, 1, 1, 0);
    check("th.ins", 64'(instr_count), 5);
    check("th.cyc", 64'(cycle_count), 7);

    wr(32'h1000, 32'h2B);
    for (int i = 0; i < 10; i++)
      retire(32'h80);
    chk_all("frz", 1, 1, 1, 0);
    check("frz.ins", 64'(instr_count), 5);
    check("frz.cyc", 64'(cycle_count), 7);

    rst = 1'b0;
    step();
    chk_all("rdn", 0, 0, 0, 0);
    check("rdn.cyc", 64'(cycle_count), 0);
    check("rdn.ins", 64'(instr_count), 0);
    rst = 1'b1;

    wr(32'h1000, 32'h2B);
    chk_all("fail", 1, 0, 1, 21);
    check("fail.cyc", 64'(cycle_count), 1);

    do_reset(1);
    for (int i = 0; i < 7; i++)
      retire(32'h40);
    check("lp7.flag", 64'(finish_flag), 0);
    retire(32'h40);
    chk_all("lp", 1, 1, 2, 0);
    check("lp.ins", 64'(instr_count), 8);

    do_reset(1);
    for (int i = 0; i < 20; i++)
      retire((i % 2) ? 32'h44 : 32'h40);
    for (int i = 0; i < 7; i++)
      retire(32'h40);
    for (int i = 0; i < 7; i++)
      retire(32'h44);
    chk_all("alt", 0, 0, 0, 0);
    check("alt.ins", 64'(instr_count), 34);

    do_reset(2);
    repeat (49) step();
    check("to49.flag", 64'(finish_flag), 0);
    check("to49.cyc", 64'(cycle_count), 49);
    step();
    chk_all("to", 1, 0, 3, 31'h7FFF_FFFF);
    check("to.cyc", 64'(cycle_count), 50);

    do_reset(1);
    for (int i = 0; i < 7; i++)
      retire(32'h40);
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h1000;
    bus.mem_wdata = 32'h5;
    retire(32'h40);
    idle();
    chk_all("pri", 1, 0, 1, 2);
    check("pri.ins", 64'(instr_count), 8);

    rst           = 1'b0;
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h1000;
    bus.mem_wdata = 32'h1;
    step();
    idle();
    chk_all("rprec", 0, 0, 0, 0);
    rst = 1'b1;
    step();
    check("rprec2.flag", 64'(finish_flag), 0);
    check("rprec2.cyc", 64'(cycle_count), 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
